// File: rtl/digitron_scan.sv
// Six-digit multiplexed 7-segment driver.
// The binary input is converted to BCD by a 22-cycle double-dabble FSM
// (IDLE capture, 20 CONV steps, LOAD). A scan counter walks the digits and
// a blink counter gates digits selected by shank_position.
// Optional build macro: DIGITRON_LEADING_ZERO_BLANK_EN blanks leading zeros
// on digits 0..4 (digit 5, the units digit, always shows).
module digitron_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] number_to_show,
  input  logic [5:0]  point_position,
  input  logic [5:0]  shank_position,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel,
  output logic [23:0] bcd_out
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t        state_q;
  logic [19:0]   bin_q;
  logic [23:0]   acc_q;
  logic [4:0]    cnt_q;
  logic          ovf_q;
  logic [23:0]   disp_q;

  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  logic [7:0]    seg_d;
  logic [5:0]    dig_sel_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in b.
  function automatic logic [23:0] dd_step(input logic [23:0] a, input logic b);
    logic [23:0] r;
    r = a;
    for (int i = 0; i < 6; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return (r << 1) | 24'(b);
  endfunction

  // Converter FSM: capture, 20 shift-add-3 steps, load display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bin_q   <= number_to_show;
          acc_q   <= '0;
          cnt_q   <= '0;
          ovf_q   <= (number_to_show > 20'd999999);
          state_q <= CONV;
        end
        CONV: begin
          acc_q <= dd_step(acc_q, bin_q[19]);
          bin_q <= {bin_q[18:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd19) state_q <= LOAD;
        end
        LOAD: begin
          // Out-of-range values show dashes on every digit.
          disp_q  <= ovf_q ? 24'hAAAAAA : acc_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_out = disp_q;

  // Scan counter: advance the digit index once every SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      idx_q      <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Blink counter: toggle the blink phase once every BLINK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Segment/select decode for the current digit.
  always_comb begin
    logic [3:0] nib;
    logic       zrun;
    logic       blank;
    nib   = 4'd0;
    zrun  = 1'b1;
    blank = 1'b0;
    for (int i = 0; i < 6; i++) begin
      zrun = zrun & (disp_q[23-4*i -: 4] == 4'd0);
      if (idx_q == 3'(i)) begin
        nib = disp_q[23-4*i -: 4];
`ifdef DIGITRON_LEADING_ZERO_BLANK_EN
        blank = zrun && (i <= 4);
`endif
      end
    end
    case (nib)
      4'd0:    seg_d = 8'hC0;
      4'd1:    seg_d = 8'hF9;
      4'd2:    seg_d = 8'hA4;
      4'd3:    seg_d = 8'hB0;
      4'd4:    seg_d = 8'h99;
      4'd5:    seg_d = 8'h92;
      4'd6:    seg_d = 8'h82;
      4'd7:    seg_d = 8'hF8;
      4'd8:    seg_d = 8'h80;
      4'd9:    seg_d = 8'h90;
      4'hA:    seg_d = 8'hBF;
      default: seg_d = 8'hFF;
    endcase
    if (blank) seg_d[6:0] = 7'h7F;
    seg_d[7] = ~point_position[idx_q];
    if (blink_phase_q && shank_position[idx_q]) seg_d = 8'hFF;
    dig_sel_d = ~(6'd1 << idx_q);
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg     <= 8'hFF;
      dig_sel <= 6'h3F;
    end else begin
      seg     <= seg_d;
      dig_sel <= dig_sel_d;
    end
  end

endmodule

// File: tb/tb_digitron_scan.sv
// Randomized bench for digitron_scan with a cycle-level reference model
// built from decimal arithmetic and the 22-cycle refresh schedule.
module tb_digitron_scan;

  localparam int S = 4;
  localparam int B = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] number_to_show = '0;
  logic [5:0]  point_position = '0;
  logic [5:0]  shank_position = '0;
  logic [7:0]  seg;
  logic [5:0]  dig_sel;
  logic [23:0] bcd_out;

  digitron_scan #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .number_to_show(number_to_show),
    .point_position(point_position), .shank_position(shank_position),
    .seg(seg), .dig_sel(dig_sel), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          k = 0;
  logic [23:0] disp_m = '0;
  int          capt = 0;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    if (v > 999999) return 24'hAAAAAA;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input logic [23:0] disp, input int idx,
                                           input logic [5:0] pt, input logic [5:0] sh,
                                           input int phase);
    logic [7:0] c;
    int d;
    d = int'(disp[23-4*idx -: 4]);
    c = digit_code(d);
`ifdef DIGITRON_LEADING_ZERO_BLANK_EN
    begin
      bit lead = 1'b1;
      for (int j = 0; j <= idx; j++)
        if (disp[23-4*j -: 4] != 4'd0) lead = 1'b0;
      if (lead && idx <= 4) c = 8'hFF;
    end
`endif
    if (pt[idx]) c[7] = 1'b0;
    if (phase == 1 && sh[idx]) c = 8'hFF;
    return c;
  endfunction

  // Advance one clock, update the model, then check all outputs.
  task automatic step();
    int idx, phase;
    @(posedge clk);
    if (rst) begin
      k = 0;
      disp_m = '0;
      exp_seg = 8'hFF;
      exp_sel = 6'h3F;
    end else begin
      k++;
      idx   = ((k - 1) / S) % 6;
      phase = ((k - 1) / B) % 2;
      exp_seg = model_seg(disp_m, idx, point_position, shank_position, phase);
      exp_sel = ~(6'd1 << idx);
      if (k % 22 == 0) disp_m = to_bcd(capt);
      if ((k - 1) % 22 == 0) capt = int'(number_to_show);
    end
    #1;
    chk("seg", {24'd0, seg}, {24'd0, exp_seg});
    chk("dig_sel", {26'd0, dig_sel}, {26'd0, exp_sel});
    chk("bcd_out", {8'd0, bcd_out}, {8'd0, disp_m});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until dig_sel selects the wanted digit, then compare its segments.
  task automatic seg_on_digit(input string tag, input logic [5:0] sel, input logic [7:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (dig_sel == sel) found = 1'b1;
    end
    if (found) chk(tag, {24'd0, seg}, {24'd0, want});
    else       chk({tag, "_sel"}, 32'd0, 32'd1);
  endtask

  initial begin
    int hold;
    int r;
    bit found;

    // Reset
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    step();
    chk("first_seg", {24'd0, seg},
`ifdef DIGITRON_LEADING_ZERO_BLANK_EN
        32'hFF
`else
        32'hC0
`endif
    );
    chk("first_sel", {26'd0, dig_sel}, 32'h3E);

    // 123456 held
    number_to_show = 20'd123456;
    run(44);
    chk("bcd_123456", {8'd0, bcd_out}, 32'h123456);
    seg_on_digit("dig2_B0", 6'b111011, 8'hB0);

    // Overflow shows dashes
    number_to_show = 20'd1000000;
    run(45);
    chk("bcd_dash", {8'd0, bcd_out}, 32'hAAAAAA);
    seg_on_digit("dash_d3", 6'b110111, 8'hBF);

    // Decimal point on digit 1 with value 300
    number_to_show = 20'd300;
    point_position = 6'b000010;
    run(45);
    seg_on_digit("pt300_d4", 6'b101111, 8'hC0);
    seg_on_digit("pt300_d1", 6'b111101,
`ifdef DIGITRON_LEADING_ZERO_BLANK_EN
                 8'h7F
`else
                 8'h40
`endif
    );
    point_position = '0;

    // Value 42
    number_to_show = 20'd42;
    run(45);
    seg_on_digit("v42_d4", 6'b101111, 8'h99);
    seg_on_digit("v42_d5", 6'b011111, 8'hA4);
    seg_on_digit("v42_d0", 6'b111110,
`ifdef DIGITRON_LEADING_ZERO_BLANK_EN
                 8'hFF
`else
                 8'hC0
`endif
    );

    // All digits blinking
    shank_position = 6'b111111;
    run(300);
    shank_position = '0;

    // Reset mid-conversion
    rst = 1'b1;
    step();
    rst = 1'b0;
    number_to_show = 20'd999999;
    run(10);
    rst = 1'b1;
    step();
    chk("midrst_seg", {24'd0, seg}, 32'hFF);
    chk("midrst_sel", {26'd0, dig_sel}, 32'h3F);
    chk("midrst_bcd", {8'd0, bcd_out}, 32'h0);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 23 && !found; i++) begin
      step();
      if (bcd_out == 24'h999999) found = 1'b1;
    end
    chk("midrst_reload", {31'd0, found}, 32'd1);

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      number_to_show = 20'($urandom_range(1000000, 1048575));
        else if (r < 4)  number_to_show = 20'($urandom_range(0, 999));
        else             number_to_show = 20'($urandom_range(0, 999999));
        point_position = 6'($urandom);
        shank_position = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
        hold = $urandom_range(1, 60);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digitron_scan.md
DIGITRON_SCAN -- requirements
Module: digitron_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit stays selected (>=2).
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (>=2).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 number_to_show  input  20  unsigned binary value, valid range 0..999999.
REQ-006 point_position  input  6  bit i set = decimal point lit on digit i.
REQ-007 shank_position  input  6  bit i set = digit i blinks.
REQ-008 seg  output  8  active-low segments: [0]=a..[6]=g, [7]=dp.
REQ-009 dig_sel  output  6  active-low one-hot digit enable; bit i = digit i.
REQ-010 bcd_out  output  24  current display register, digit i at bits [23-4i:20-4i].

Function
REQ-011 Digit i SHALL have weight 10^(5-i): digit 0 = hundred-thousands, digit 5 = units.
REQ-012 Converter FSM SHALL have states IDLE, CONV, LOAD.
REQ-013 IDLE SHALL capture number_to_show, clear the BCD accumulator, and go to CONV in one cycle.
REQ-014 CONV SHALL run shift-add-3 (double dabble) for exactly 20 cycles, then go to LOAD.
REQ-015 LOAD SHALL write the result to the display register and bcd_out, then return to IDLE.
REQ-016 Refresh period SHALL be 22 cycles; bcd_out SHALL reflect a sample at most 44 cycles old.
REQ-017 Input changes during CONV/LOAD SHALL be ignored until the next IDLE capture.
REQ-018 A captured value >999999 SHALL load the dash code (4'hA) into all six digits.
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index SHALL advance 0->1->...->5->0.
REQ-020 Blink counter SHALL count 0..BLINK_DIV-1; blink_phase SHALL toggle on each wrap.
REQ-021 seg and dig_sel SHALL be registered, one cycle after digit index / display register.
REQ-022 dig_sel SHALL drive low only the bit of the current digit index.
REQ-023 Segment codes (dp=1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF.
REQ-024 seg[7] SHALL be 0 when point_position[index]=1, independent of digit code.
REQ-025 When blink_phase=1 and shank_position[index]=1, seg SHALL be 8'hFF (dp included).
REQ-026 shank_position=6'b111111 SHALL blink all digits in phase.
REQ-027 point_position/shank_position SHALL be sampled each cycle, not captured by the converter.

Reset
REQ-028 On rst=1 at a clk edge: seg=8'hFF, dig_sel=6'h3F, bcd_out=0, display register=0.
REQ-029 On rst=1 also: FSM=IDLE, digit index=0, scan/blink counters=0, blink_phase=0.
REQ-030 rst mid-CONV SHALL discard the partial conversion; first capture on the first cycle after rst deasserts.
REQ-031 The first cycle after reset SHALL output digit 0 of a zero display register.

Configuration
REQ-032 Macro DIGITRON_LEADING_ZERO_BLANK_EN, when defined, SHALL blank digit i (i<=4) if it and all more-significant digits are 0.
REQ-033 A blanked digit SHALL output segments a-g off; dp per REQ-024; digit 5 is never blanked.
REQ-034 Dash digits SHALL never be blanked.
REQ-035 Without the macro, all six digits SHALL always display, including leading zeros.

Verification (SCAN_DIV=4, BLINK_DIV=64)
REQ-036 number_to_show=123456 held 44 cycles -> bcd_out=24'h123456; digit 2 selected: dig_sel=6'b111011, seg=8'hB0.
REQ-037 number_to_show=1000000 -> bcd_out=24'hAAAAAA; every digit shows seg=8'hBF.
REQ-038 point_position=6'b000010, value 000300, macro off -> digit 4 seg=8'hC0, digit 1 seg=8'h40.
REQ-039 shank_position=6'b111111 -> seg=8'hFF for 64 cycles, then digit codes for 64 cycles, repeating.
REQ-040 value 42, macro on -> digits 0-3 seg=8'hFF, digit 4 seg=8'h99, digit 5 seg=8'hA4; macro off -> digits 0-3 seg=8'hC0.
REQ-041 rst pulsed mid-CONV with 999999 applied -> next cycle seg=8'hFF, dig_sel=6'h3F, bcd_out=0; bcd_out=24'h999999 within 23 cycles after release.
